uart_ns_rx: RTL and testbench

UART receive engine; the receive-side counterpart of the UART transmitter in the same peripheral.
- Recovers 8N1/8N2 frames from the asynchronous rx pin, LSB first, start bit low, stop bit(s) high.
- Timing: one bit period equals baud_div_i clock cycles, matching the transmit side.
- Delivers each byte through a single-entry valid/ready holding register to the UART register/FIFO layer.

---
 rtl/uart_defs.sv | 19 +
 rtl/uart_ns_rx_sync.sv | 48 ++++
 rtl/uart_ns_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_ns_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: frame/divisor widths and the receive-engine state encoding.
package uart_defs;

  localparam int UART_DATA_SIZE       = 8;
  localparam int UART_BAUD_DIV_SIZE   = 16;
  localparam int UART_RX_MIN_BAUD_DIV = 4;

  typedef enum logic [1:0] {
    UART_RX_IDLE,
    UART_RX_START,
    UART_RX_DATA,
    UART_RX_STOP
  } type_uart_rx_states_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_ns_rx_sync.sv
// Two-flop synchronizer and falling-edge detect for the UART rx pin.
// With UART_RX_MAJORITY_EN defined, sample_bit_o is a 2-of-3 vote over the last three synchronized samples.
module uart_ns_rx_sync
  import uart_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_pin_i,
  output logic fall_edge_o,
  output logic sample_bit_o
);

  logic rxMeta_q;
  logic rxSync_q;
  logic rxPrev_q;

  // Flops preset high so an idle line never looks like a start edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_pin_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  assign fall_edge_o = rxPrev_q & ~rxSync_q;

`ifdef UART_RX_MAJORITY_EN
  logic rxPrev2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxPrev2_q <= 1'b1;
    end else begin
      rxPrev2_q <= rxPrev_q;
    end
  end

  assign sample_bit_o = majority3({rxPrev2_q, rxPrev_q, rxSync_q});
`else
  assign sample_bit_o = rxSync_q;
`endif

endmodule

// File: rtl/uart_ns_rx.sv
// UART receive engine: 8N1/8N2 frame recovery into a single-entry valid/ready holding register.
// Optional UART_RX_MAJORITY_EN enables 2-of-3 majority sampling inside uart_ns_rx_sync.
module uart_ns_rx
  import uart_defs::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_pin_i,
  input  logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i,
  input  logic                          two_stop_bits,
  input  logic                          ready_i,
  output logic [UART_DATA_SIZE-1:0]     rx_data_o,
  output logic                          valid_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(UART_DATA_SIZE);

  type_uart_rx_states_e state_q, state_d;
  logic [UART_BAUD_DIV_SIZE-1:0] sampleCount_q, sampleCount_d;
  logic [UART_BAUD_DIV_SIZE-1:0] divLatch_q, divLatch_d;
  logic [IDX_W-1:0]              bitIdx_q, bitIdx_d;
  logic                          stopIdx_q, stopIdx_d;
  logic                          twoStop_q, twoStop_d;
  logic                          errAcc_q, errAcc_d;
  logic [UART_DATA_SIZE-1:0]     shift_q, shift_d;
  logic [UART_DATA_SIZE-1:0]     rxData_q, rxData_d;
  logic                          valid_q, valid_d;
  logic                          frameErr_q, frameErr_d;
  logic                          overrun_q, overrun_d;

  logic                          fallEdge;
  logic                          sampleBit;
  logic                          samplePoint;
  logic                          complete;
  logic                          completeErr;
  logic [UART_BAUD_DIV_SIZE-1:0] effDiv;

  uart_ns_rx_sync uSync (
    .clk          (clk),
    .rst          (rst),
    .rx_pin_i     (rx_pin_i),
    .fall_edge_o  (fallEdge),
    .sample_bit_o (sampleBit)
  );

  // Divisors below the legal minimum are clamped so the half-bit load never reaches zero.
  assign effDiv = (baud_div_i < UART_BAUD_DIV_SIZE'(UART_RX_MIN_BAUD_DIV)) ?
                  UART_BAUD_DIV_SIZE'(UART_RX_MIN_BAUD_DIV) : baud_div_i;
  assign samplePoint = (sampleCount_q == UART_BAUD_DIV_SIZE'(1));

  always_comb begin
    state_d       = state_q;
    sampleCount_d = sampleCount_q;
    divLatch_d    = divLatch_q;
    bitIdx_d      = bitIdx_q;
    stopIdx_d     = stopIdx_q;
    twoStop_d     = twoStop_q;
    errAcc_d      = errAcc_q;
    shift_d       = shift_q;
    rxData_d      = rxData_q;
    valid_d       = valid_q;
    frameErr_d    = frameErr_q;
    overrun_d     = 1'b0;
    complete      = 1'b0;
    completeErr   = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (state_q != UART_RX_IDLE) begin
      sampleCount_d = samplePoint ? divLatch_q : sampleCount_q - UART_BAUD_DIV_SIZE'(1);
    end

    unique case (state_q)
      UART_RX_IDLE: begin
        if (fallEdge) begin
          divLatch_d    = effDiv;
          twoStop_d     = two_stop_bits;
          sampleCount_d = effDiv >> 1;
          errAcc_d      = 1'b0;
          state_d       = UART_RX_START;
        end
      end
      UART_RX_START: begin
        if (samplePoint) begin
          if (sampleBit) begin
            state_d = UART_RX_IDLE;
          end else begin
            bitIdx_d = '0;
            state_d  = UART_RX_DATA;
          end
        end
      end
      UART_RX_DATA: begin
        if (samplePoint) begin
          shift_d = {sampleBit, shift_q[UART_DATA_SIZE-1:1]};
          if (bitIdx_q == IDX_W'(UART_DATA_SIZE - 1)) begin
            stopIdx_d = 1'b0;
            state_d   = UART_RX_STOP;
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
          end
        end
      end
      UART_RX_STOP: begin
        if (samplePoint) begin
          if (!sampleBit) begin
            errAcc_d = 1'b1;
          end
          if (!twoStop_q || stopIdx_q) begin
            complete    = 1'b1;
            completeErr = errAcc_q | ~sampleBit;
            state_d     = UART_RX_IDLE;
          end else begin
            stopIdx_d = 1'b1;
          end
        end
      end
      default: state_d = UART_RX_IDLE;
    endcase

    // A consumer taking the old byte in the completion cycle frees the slot for the new one.
    if (complete) begin
      if (!valid_q || ready_i) begin
        rxData_d   = shift_q;
        frameErr_d = completeErr;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= UART_RX_IDLE;
      sampleCount_q <= '0;
      divLatch_q    <= '0;
      bitIdx_q      <= '0;
      stopIdx_q     <= 1'b0;
      twoStop_q     <= 1'b0;
      errAcc_q      <= 1'b0;
      shift_q       <= '0;
      rxData_q      <= '0;
      valid_q       <= 1'b0;
      frameErr_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sampleCount_q <= sampleCount_d;
      divLatch_q    <= divLatch_d;
      bitIdx_q      <= bitIdx_d;
      stopIdx_q     <= stopIdx_d;
      twoStop_q     <= twoStop_d;
      errAcc_q      <= errAcc_d;
      shift_q       <= shift_d;
      rxData_q      <= rxData_d;
      valid_q       <= valid_d;
      frameErr_q    <= frameErr_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data_o   = rxData_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != UART_RX_IDLE);

endmodule

// File: tb/tb_uart_ns_rx.sv
// Scoreboard testbench for uart_ns_rx: directed frames, expected bytes queued, checked on handshake.
module tb_uart_ns_rx;
  import uart_defs::*;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          rx_pin_i;
  logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i;
  logic                          two_stop_bits;
  logic                          ready_i;
  logic [UART_DATA_SIZE-1:0]     rx_data_o;
  logic                          valid_o;
  logic                          frame_err_o;
  logic                          overrun_o;
  logic                          busy_o;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   checkCount  = 0;
  int   passCount   = 0;
  int   overrunSeen = 0;
  logic overrunPrev = 1'b0;

  uart_ns_rx dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin_i      (rx_pin_i),
    .baud_div_i    (baud_div_i),
    .two_stop_bits (two_stop_bits),
    .ready_i       (ready_i),
    .rx_data_o     (rx_data_o),
    .valid_o       (valid_o),
    .frame_err_o   (frame_err_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  task automatic expectByte(input logic [7:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    expQ.push_back(x);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit period; a glitch inverts the line for the single cycle the receiver samples.
  task automatic driveBit(input logic level, input logic glitch);
    int d;
    int half;
    d    = int'(baud_div_i);
    half = d / 2;
    rx_pin_i = level;
    if (glitch) begin
      repeat (half) @(posedge clk);
      #1 rx_pin_i = ~level;
      @(posedge clk);
      #1 rx_pin_i = level;
      repeat (d - half - 1) @(posedge clk);
      #1;
    end else begin
      repeat (d) @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopLevel, input logic glitch);
    driveBit(1'b0, glitch);
    for (int i = 0; i < 8; i++) driveBit(data[i], glitch);
    driveBit(stopLevel, glitch);
    if (two_stop_bits) driveBit(stopLevel, glitch);
  endtask

  // Consumer side: every accepted byte is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedByte: got 0x%0h, want no byte", rx_data_o);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("rxData", int'(rx_data_o), int'(e.data));
          checkOutput("frameErr", int'(frame_err_o), int'(e.err));
        end
      end
      if (overrun_o) begin
        overrunSeen++;
        if (overrunPrev) begin
          checkCount++;
          $display("[TB] FAIL overrunWidth: got pulse of 2+ cycles, want 1 cycle");
        end
      end
      overrunPrev = overrun_o;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    rx_pin_i      = 1'b1;
    baud_div_i    = 16'd16;
    two_stop_bits = 1'b0;
    ready_i       = 1'b1;
    idleCycles(3);
    checkOutput("resetValid", int'(valid_o), 0);
    checkOutput("resetData", int'(rx_data_o), 0);
    checkOutput("resetFrameErr", int'(frame_err_o), 0);
    checkOutput("resetOverrun", int'(overrun_o), 0);
    checkOutput("resetBusy", int'(busy_o), 0);
    rst = 1'b0;
    idleCycles(4);

    $display("[TB] nominal byte");
    expectByte(8'hA5, 1'b0);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    idleCycles(8);

    $display("[TB] two stop bits, back to back");
    two_stop_bits = 1'b1;
    expectByte(8'h3C, 1'b0);
    expectByte(8'hC3, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    idleCycles(8);
    two_stop_bits = 1'b0;
    idleCycles(8);

    $display("[TB] false start");
    rx_pin_i = 1'b0;
    idleCycles(5);
    rx_pin_i = 1'b1;
    idleCycles(24);
    checkOutput("falseStartBusy", int'(busy_o), 0);
    expectByte(8'h55, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    idleCycles(8);

    $display("[TB] framing error and held-low line");
    expectByte(8'h0F, 1'b1);
    applyStimulus(8'h0F, 1'b0, 1'b0);
    idleCycles(320);
    checkOutput("heldLowBusy", int'(busy_o), 0);
    rx_pin_i = 1'b1;
    idleCycles(32);

    $display("[TB] overrun");
    ready_i = 1'b0;
    expectByte(8'h11, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    idleCycles(8);
    checkOutput("heldValid", int'(valid_o), 1);
    applyStimulus(8'h22, 1'b1, 1'b0);
    idleCycles(8);
    checkOutput("overrunCount", overrunSeen, 1);
    checkOutput("heldData", int'(rx_data_o), 8'h11);
    expectByte(8'h33, 1'b0);
    fork
      applyStimulus(8'h33, 1'b1, 1'b0);
      begin
        repeat (154) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    idleCycles(8);
    checkOutput("noOverrunOnReplace", overrunSeen, 1);

    $display("[TB] reset mid-frame");
    ready_i = 1'b0;
    applyStimulus(8'h77, 1'b1, 1'b0);
    idleCycles(8);
    checkOutput("preResetData", int'(rx_data_o), 8'h77);
    fork
      applyStimulus(8'hF0, 1'b1, 1'b0);
      begin
        repeat (85) @(posedge clk);
        #1;
        checkOutput("preResetBusy", int'(busy_o), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midResetValid", int'(valid_o), 0);
        checkOutput("midResetBusy", int'(busy_o), 0);
        checkOutput("midResetData", int'(rx_data_o), 0);
        rst = 1'b0;
      end
    join
    ready_i = 1'b1;
    idleCycles(16);
    expectByte(8'h96, 1'b0);
    applyStimulus(8'h96, 1'b1, 1'b0);
    idleCycles(8);

    $display("[TB] minimum divisor");
    baud_div_i = 16'd4;
    expectByte(8'hE7, 1'b0);
    applyStimulus(8'hE7, 1'b1, 1'b0);
    idleCycles(8);
    baud_div_i = 16'd16;

`ifdef UART_RX_MAJORITY_EN
    $display("[TB] majority vote against sample-point glitches");
    expectByte(8'h96, 1'b0);
    applyStimulus(8'h96, 1'b1, 1'b1);
    idleCycles(8);
`endif

    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("overrunTotal", overrunSeen, 1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
